// File: rtl/ysyx_22040386_lsu_pkg.sv
// ysyx_22040386_lsu_pkg
// Shared types for the MEM-stage load/store unit.
// - lsu_state_e : bus transaction FSM states.
// - lsu_size_e  : access size, taken from funct3[1:0].
// - size_bytes  : number of bytes covered by an access size.
package ysyx_22040386_lsu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W,
    SZ_D
  } lsu_size_e;

  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/ysyx_22040386_lsu_if.sv
// ysyx_22040386_lsu_if
// req/gnt/rvalid memory bus between the LSU and the memory side.
// Signal names keep the LSU's point of view (o_ = driven by the LSU).
// - master : LSU side (drives req/we/addr/wdata/wmask).
// - slave  : memory side (drives gnt/rvalid/rdata/err).
interface ysyx_22040386_lsu_if #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64
);
  localparam int NB = XLEN / 8;

  logic              o_bus_req;
  logic              i_bus_gnt;
  logic              o_bus_we;
  logic [ADDR_W-1:0] o_bus_addr;
  logic [XLEN-1:0]   o_bus_wdata;
  logic [NB-1:0]     o_bus_wmask;
  logic              i_bus_rvalid;
  logic [XLEN-1:0]   i_bus_rdata;
  logic              i_bus_err;

  modport master (
    output o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_wmask,
    input  i_bus_gnt, i_bus_rvalid, i_bus_rdata, i_bus_err
  );

  modport slave (
    input  o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_wmask,
    output i_bus_gnt, i_bus_rvalid, i_bus_rdata, i_bus_err
  );

endinterface

// File: rtl/ysyx_22040386_lsu_align.sv
// ysyx_22040386_lsu_align
// Combinational lane steering for the LSU.
// Inputs : size, uns (zero-extend), ofs (byte offset in beat),
//          wdata (right-aligned store data), rdata (raw read beat).
// Outputs: wmask (byte enables), wdata_sh (store data in its lanes),
//          rdata_ext (load data shifted down, truncated and extended).
module ysyx_22040386_lsu_align
  import ysyx_22040386_lsu_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int NB    = XLEN / 8,
  parameter int OFS_W = $clog2(NB)
) (
  input  lsu_size_e        size,
  input  logic             uns,
  input  logic [OFS_W-1:0] ofs,
  input  logic [XLEN-1:0]  wdata,
  input  logic [XLEN-1:0]  rdata,
  output logic [NB-1:0]    wmask,
  output logic [XLEN-1:0]  wdata_sh,
  output logic [XLEN-1:0]  rdata_ext
);

  int unsigned     nbytes;
  int unsigned     nbits;
  logic            sign;
  logic [XLEN-1:0] sh;
  logic [NB-1:0]   base;

  always_comb begin
    nbytes = 32'(size_bytes(size));
    nbits  = nbytes * 8;
    if (nbits > 32'(XLEN)) nbits = 32'(XLEN);

    for (int unsigned i = 0; i < 32'(NB); i++) base[i] = (i < nbytes);
    wmask    = base << ofs;
    wdata_sh = wdata << {ofs, 3'b000};

    sh   = rdata >> {ofs, 3'b000};
    // Locate the MSB of the access with a compare rather than a variable
    // index so the select never runs past XLEN for oversized accesses.
    sign = 1'b0;
    for (int unsigned i = 0; i < 32'(XLEN); i++) begin
      if (i == nbits - 1) sign = sh[i];
    end
    sign = sign & ~uns;
    for (int unsigned i = 0; i < 32'(XLEN); i++) begin
      rdata_ext[i] = (i < nbits) ? sh[i] : sign;
    end
  end

endmodule

// File: rtl/ysyx_22040386_lsu.sv
// ysyx_22040386_lsu
// MEM-stage load/store unit driving a multi-cycle req/gnt/rvalid bus.
// One request at a time; the upstream pipeline is held via o_lsu_stall.
// Ports:
//   i_clk, i_rst_n (async, active-low)
//   i_lsu_valid/ren/wen/mask/addr/wdata : request from MEM
//   o_lsu_ready/stall/done/rdata/err    : status and result to MEM
//   bus (ysyx_22040386_lsu_if.master)   : memory bus
// Build option: LSU_MISALIGN_EXC_EN -- when defined, misaligned accesses
// complete with o_lsu_err and no bus transfer; otherwise the offset is
// aligned down to the access size.
module ysyx_22040386_lsu
  import ysyx_22040386_lsu_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_lsu_valid,
  input  logic              i_lsu_ren,
  input  logic              i_lsu_wen,
  input  logic [2:0]        i_lsu_mask,
  input  logic [ADDR_W-1:0] i_lsu_addr,
  input  logic [XLEN-1:0]   i_lsu_wdata,
  output logic              o_lsu_ready,
  output logic              o_lsu_stall,
  output logic              o_lsu_done,
  output logic [XLEN-1:0]   o_lsu_rdata,
  output logic              o_lsu_err,
  ysyx_22040386_lsu_if.master bus
);

  localparam int NB    = XLEN / 8;
  localparam int OFS_W = $clog2(NB);

  lsu_state_e        state;
  logic [ADDR_W-1:0] addr_q;
  lsu_size_e         size_q;
  logic              uns_q;
  logic [XLEN-1:0]   wdata_q;
  logic              we_q;
  logic [XLEN-1:0]   rdata_q;
  logic              err_q;

  logic              req_act;
  lsu_size_e         in_size;
  logic              illegal;
  logic [OFS_W-1:0]  gran_q;
  logic [OFS_W-1:0]  ofs_eff;
  logic [NB-1:0]     wmask;
  logic [XLEN-1:0]   wdata_sh;
  logic [XLEN-1:0]   rdata_ext;
  logic [XLEN-1:0]   rsp_rdata;

  assign req_act = i_lsu_valid & (i_lsu_ren | i_lsu_wen);
  assign in_size = lsu_size_e'(i_lsu_mask[1:0]);

`ifdef LSU_MISALIGN_EXC_EN
  logic [OFS_W-1:0] in_gran;
  logic             misaligned;
  assign in_gran    = OFS_W'(size_bytes(in_size) - 4'd1);
  assign misaligned = (i_lsu_addr[OFS_W-1:0] & in_gran) != '0;
  assign illegal    = (i_lsu_ren & i_lsu_wen)
                    | ((XLEN == 32) && (in_size == SZ_D))
                    | misaligned;
`else
  assign illegal    = (i_lsu_ren & i_lsu_wen)
                    | ((XLEN == 32) && (in_size == SZ_D));
`endif

  // Clearing the sub-granule offset bits aligns the access down; with the
  // misalignment check enabled those bits are already zero on the bus path.
  assign gran_q  = OFS_W'(size_bytes(size_q) - 4'd1);
  assign ofs_eff = addr_q[OFS_W-1:0] & ~gran_q;

  ysyx_22040386_lsu_align #(
    .XLEN (XLEN),
    .NB   (NB),
    .OFS_W(OFS_W)
  ) u_align (
    .size     (size_q),
    .uns      (uns_q),
    .ofs      (ofs_eff),
    .wdata    (wdata_q),
    .rdata    (bus.i_bus_rdata),
    .wmask    (wmask),
    .wdata_sh (wdata_sh),
    .rdata_ext(rdata_ext)
  );

  assign rsp_rdata = (bus.i_bus_err | we_q) ? '0 : rdata_ext;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      addr_q  <= '0;
      size_q  <= SZ_B;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_act) begin
            addr_q  <= i_lsu_addr;
            size_q  <= in_size;
            uns_q   <= i_lsu_mask[2];
            wdata_q <= i_lsu_wdata;
            we_q    <= i_lsu_wen;
            if (illegal) begin
              err_q   <= 1'b1;
              rdata_q <= '0;
              state   <= DONE;
            end else begin
              state   <= REQ;
            end
          end
        end
        REQ: begin
          if (bus.i_bus_gnt) begin
            if (bus.i_bus_rvalid) begin
              err_q   <= bus.i_bus_err;
              rdata_q <= rsp_rdata;
              state   <= DONE;
            end else begin
              state   <= WAIT;
            end
          end
        end
        WAIT: begin
          if (bus.i_bus_rvalid) begin
            err_q   <= bus.i_bus_err;
            rdata_q <= rsp_rdata;
            state   <= DONE;
          end
        end
        DONE: begin
          err_q   <= 1'b0;
          rdata_q <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_lsu_ready = (state == IDLE);
  assign o_lsu_done  = (state == DONE);
  assign o_lsu_rdata = rdata_q;
  assign o_lsu_err   = err_q;
  assign o_lsu_stall = ((state == IDLE) & req_act) | (state == REQ) | (state == WAIT);

  assign bus.o_bus_req   = (state == REQ);
  assign bus.o_bus_we    = we_q;
  assign bus.o_bus_addr  = {addr_q[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
  assign bus.o_bus_wdata = wdata_sh;
  assign bus.o_bus_wmask = wmask;

endmodule

// File: doc/ysyx_22040386_lsu.md
Name: ysyx_22040386_lsu

Overview:
- Parametrised load/store unit for the MEM stage; successor to the combinational DPI-C memory path.
- Takes one load or store request from MEM. Drives a multi-cycle req/gnt/rvalid bus. Generates byte lanes and write mask. Extracts and sign- or zero-extends load data.
- Holds the pipeline with `o_lsu_stall` until the bus responds. Supports XLEN 32 or 64 and bus error reporting.

Parameters:
- XLEN, 64, data width; legal values 32 or 64; bus width equals XLEN.
- ADDR_W, 64, address width.
- NB, XLEN/8, derived; bytes per bus beat; OFS_W = log2(NB).

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_lsu_valid  in  1  MEM stage presents a request.
- i_lsu_ren  in  1  load.
- i_lsu_wen  in  1  store.
- i_lsu_mask  in  3  funct3 encoding. [1:0] is size: 0=B, 1=H, 2=W, 3=D. [2]=1 means zero-extend.
- i_lsu_addr  in  ADDR_W  byte address.
- i_lsu_wdata  in  XLEN  store data, right-aligned.
- o_lsu_ready  out  1  request can be accepted.
- o_lsu_stall  out  1  freeze upstream pipeline registers.
- o_lsu_done  out  1  one-cycle completion pulse.
- o_lsu_rdata  out  XLEN  extended load result; valid while o_lsu_done=1.
- o_lsu_err  out  1  completion carries an error; valid with o_lsu_done.
- o_bus_req  out  1  bus request.
- i_bus_gnt  in  1  request accepted.
- o_bus_we  out  1  write.
- o_bus_addr  out  ADDR_W  address with low OFS_W bits cleared.
- o_bus_wdata  out  XLEN  store data shifted into its lanes.
- o_bus_wmask  out  NB  byte enables.
- i_bus_rvalid  in  1  response or write acknowledge.
- i_bus_rdata  in  XLEN  read beat.
- i_bus_err  in  1  error response; qualified by i_bus_rvalid.

Behaviour:
- Reset, asynchronous:
  - state=IDLE.
  - o_bus_req, o_lsu_done, o_lsu_err all 0.
  - o_lsu_rdata=0.
  - Latched request fields cleared.
  - o_lsu_ready=1.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - o_lsu_ready=1.
  - Accept when i_lsu_valid & (ren|wen): latch addr, mask, wdata, we.
  - If the request is illegal, go to DONE with err=1 and no bus transfer. Otherwise go to REQ.
  - i_lsu_valid with neither ren nor wen is ignored; no stall.
- Illegal requests: ren&wen both set; size D when XLEN=32; misaligned address (macro-dependent, see Optional Feature).
- REQ:
  - o_bus_req=1. addr, we, wdata and wmask stay stable until i_bus_gnt.
  - gnt & !rvalid: go to WAIT.
  - gnt & rvalid in the same cycle: go directly to DONE.
- WAIT:
  - o_bus_req=0.
  - On i_bus_rvalid: go to DONE.
  - i_bus_err=1 at that response sets err and forces rdata=0.
- DONE, one cycle:
  - o_lsu_done=1.
  - o_lsu_rdata and o_lsu_err are registered values.
  - o_lsu_ready=0, so back-to-back accesses incur one bubble.
  - Next state is IDLE.
- Stall: o_lsu_stall = (IDLE & i_lsu_valid & (ren|wen)) | REQ | WAIT. It is 0 in DONE.
- Latency: minimum 2 cycles from accept to done (accept cycle 0, gnt+rvalid at cycle 1, done at cycle 2).
- Lane and mask rules:
  - ofs = addr[OFS_W-1:0].
  - wmask = ((1<<size_bytes)-1) << ofs.
  - bus wdata = wdata << (8*ofs).
- Load data: take rdata >> (8*ofs), truncate to size, then sign-extend from the MSB unless mask[2]=1. Size D ignores mask[2].
- Stores return o_lsu_rdata=0.
- rvalid outside WAIT or REQ is ignored.
- Reset asserted mid-transaction aborts it. No completion is generated, and a late bus response is ignored.

Optional Feature:
- Macro: LSU_MISALIGN_EXC_EN.
- Defined: misalignment means `ofs % size_bytes != 0`. A misaligned access completes via DONE with o_lsu_err=1, o_lsu_rdata=0, and no o_bus_req.
- Undefined: ofs low bits below the size granule are forced to 0 (aligned down). The access proceeds normally and never errors on alignment.

Decomposition:
- Package ysyx_22040386_lsu_pkg:
  - State enum (IDLE/REQ/WAIT/DONE).
  - Size encodings SZ_B/SZ_H/SZ_W/SZ_D.
  - Function size_bytes(size).
- Sub-module ysyx_22040386_lsu_align, purely combinational. Takes size, unsigned, ofs, wdata and rdata. Produces wmask, shifted wdata, and extended rdata. The FSM stays in the top module.

Test Plan (XLEN=64):
- sb, addr=0x8000_0003, wdata=0xAB; gnt on 2nd REQ cycle, rvalid 1 cycle later.
  - Bus: addr=0x8000_0000, wmask=0x08, wdata=0x0000_0000_AB00_0000.
  - stall high until done; done 4 cycles after accept.
- lb / lbu, addr=0x8000_0005, rdata=0x0000_8000_0000_0000; gnt and rvalid in the same cycle.
  - lb returns 0xFFFF_FFFF_FFFF_FF80; lbu returns 0x80.
  - done at cycle 2.
- lw / lwu, addr=0x8000_0004, rdata=0xDEAD_BEEF_0000_0000.
  - lw returns 0xFFFF_FFFF_DEAD_BEEF; lwu returns 0x0000_0000_DEAD_BEEF.
- ld with i_bus_err=1 on rvalid: o_lsu_err=1 and o_lsu_rdata=0 for exactly one done cycle, then ready=1.
- lh, addr=0x8000_0001:
  - With macro: err=1 and no o_bus_req.
  - Without macro: bus request with wmask-equivalent offset 0, result from bytes[1:0].
- i_rst_n low for 1 cycle during WAIT, then rvalid pulses: state IDLE, done stays 0, outputs at reset values.
